vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Source end of the `vga` pixel interface: generates the raster position (`pxl_x`, `pxl_y`), sync pulses and the active-video flag that every drawing block downstream consumes through `vga.in`. It sits at the head of the video pipeline, driven by the pixel-rate enable. Drawing objects, e.g. the starfield, key their per-frame behaviour off its (0,0) position. Colour fields are driven to zero here and are filled in by the drawing and mixing stages.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP` / `H_SYNC` / `H_BP`, 16 / 96 / 48, horizontal front porch, sync and back porch, in pixels
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP` / `V_SYNC` / `V_BP`, 10 / 2 / 33, vertical front porch, sync and back porch, in lines
- `SYNC_POL`, 0, asserted level of `hsync`/`vsync`; 0 means active-low
- `clk  in  1`  system clock
- `resetN  in  1`  reset, asynchronous, active-low
- `en  in  1`  pixel enable; the raster advances one pixel per `clk` with `en`=1
- `o  vga.out  -`  drives `o.t.pxl_x`, `o.t.pxl_y`, `o.t.hsync`, `o.t.vsync`, `o.t.active`, and `o.t.red/green/blue` (always 4'h0)
- `line_start  out  1`  one-clk pulse while the presented pixel has `pxl_x`=0
- `frame_start  out  1`  one-clk pulse while the presented pixel is (0,0)
- `frame_cnt  out  16`  frame counter; present only with the macro below

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Counter widths: X_W = $clog2(H_TOTAL), Y_W = $clog2(V_TOTAL). `pxl_x`/`pxl_y` carry these widths, zero-extended to the interface field width.
- `hcnt`/`vcnt` hold the position of the next pixel to present.
- On a clk with `en`=1: outputs <= decode(hcnt,vcnt), then advance.
  - hcnt==H_TOTAL-1 wraps hcnt to 0 and increments vcnt.
  - vcnt==V_TOTAL-1 with an hcnt wrap takes vcnt to 0.
- Decode:
  - `active` = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - `hsync` is asserted for hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1].
  - `vsync` is asserted for vcnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1], for whole lines.
- `pxl_x`/`pxl_y` run over the full total range, including blanking. Colours are forced to 0.
- `en`=0: position, sync and `active` outputs hold; `line_start`/`frame_start` drop to 0 (pulses never stretch).
- Legality, checked by an elaboration-time assertion: H_SYNC≥1, V_SYNC≥1, H_ACTIVE≥1, V_ACTIVE≥1. Porches may be 0.

## Timing
- All outputs are registered. They present a pixel one clk after the `en` edge that sampled it.
- Reset (async assert, any time, including mid-frame): hcnt=vcnt=0, `pxl_x`=`pxl_y`=0, `active`=0, `hsync`/`vsync` at inactive level (~SYNC_POL), pulses 0, `frame_cnt`=0.
- The first `en` clk after reset release presents (0,0) with `active`=1, `line_start`=1, `frame_start`=1.
- Frame period is H_TOTAL×V_TOTAL `en` cycles (420000 with defaults).

## Configuration
- `VGA_TIMING_FRAME_CNT_EN` defined:
  - Port `frame_cnt[15:0]` exists.
  - It increments on the same clk that `frame_start` is registered high, and wraps 16'hFFFF→0.
  - The first frame after reset reads 1 while (0,0) is presented.
- Undefined: the port and its register are absent; all other behaviour is identical.

## Structure
- `vga_timing_pkg` holds the default timing localparams (640x480@60 set) and a `vga_mode_t` struct of the eight timing values. Other top-levels pass this struct when they need alternate modes.
- Sub-module `vga_axis_counter`: parameterised (TOTAL, SYNC_START, SYNC_LEN, ACTIVE_LEN) wrap counter with a step input.
  - Outputs: count, terminal flag, active, sync.
  - Instantiated twice: the horizontal instance steps on `en`; the vertical instance steps on `en` && h-terminal.

## Test plan
- Reset, then `en`=1 continuously -> first presented pixel (0,0), `active`=1, `frame_start`=`line_start`=1, `hsync`=`vsync`=1.
- Line sweep on line 0 -> `active` drops at `pxl_x`=640; `hsync` is low for `pxl_x` 656..751 (exactly 96 clks) and high at 752.
- Line wrap -> after (799,0) the next pixel is (0,1) with `line_start`=1, `frame_start`=0.
- Frame wrap -> after (799,524) the next pixel is (0,0) with `frame_start`=1, 420000 clks apart.
  - `vsync` is low for lines 490..491 (1600 clks).
  - With the macro, `frame_cnt` reads 1 then 2 at successive frame starts.
- `en` alternating 1/0 -> outputs hold during `en`=0; pulses last one clk only; frame period is 840000 clks.
- Async reset asserted at (300,200) -> outputs reach reset values without waiting for a clk edge. After release, the first `en` clk presents (0,0) with `frame_start`=1.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster timing, the mode bundle struct and the pixel bus payload.
// Pure declarations; no logic, no latency.
// No flow control lives here; consumers follow the pixel enable.
package vga_timing_pkg;

  // 640x480@60 timing, in pixels (horizontal) and lines (vertical)
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  // Width of the position fields on the pixel bus; wide enough for modes beyond 2048.
  localparam int PXL_W = 12;

  // Timing of one video mode; alternate top-levels pass one of these around.
  typedef struct packed {
    int h_active;
    int h_fp;
    int h_sync;
    int h_bp;
    int v_active;
    int v_fp;
    int v_sync;
    int v_bp;
  } vga_mode_t;

  localparam vga_mode_t VGA_MODE_DEFAULT = '{
    h_active: DEF_H_ACTIVE, h_fp: DEF_H_FP, h_sync: DEF_H_SYNC, h_bp: DEF_H_BP,
    v_active: DEF_V_ACTIVE, v_fp: DEF_V_FP, v_sync: DEF_V_SYNC, v_bp: DEF_V_BP
  };

  // One presented pixel as it travels down the video pipeline.
  typedef struct packed {
    logic [PXL_W-1:0] pxl_x;
    logic [PXL_W-1:0] pxl_y;
    logic             hsync;
    logic             vsync;
    logic             active;
    logic [3:0]       red;
    logic [3:0]       green;
    logic [3:0]       blue;
  } vga_t;

  // Total length of one axis: active + front porch + sync + back porch.
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel bus between the timing generator, drawing objects and mixers.
// Carries one presented pixel; no latency of its own.
// No backpressure: the bus is sampled on the pixel enable.
interface vga;
  import vga_timing_pkg::*;

  vga_t t;

  modport out (output t);
  modport in  (input  t);

endinterface

// File: rtl/vga_axis_counter.sv
// Wrap counter for one raster axis with combinational terminal/active/sync decode.
// Decode is combinational from the count register; the count advances one clk after step.
// No backpressure: the count holds whenever step is low.
module vga_axis_counter #(
  parameter int TOTAL      = 800,
  parameter int SYNC_START = 656,
  parameter int SYNC_LEN   = 96,
  parameter int ACTIVE_LEN = 640
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     step,
  output logic [$clog2(TOTAL)-1:0] count,
  output logic                     term,
  output logic                     active,
  output logic                     sync
);

  localparam int W = $clog2(TOTAL);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;
  int           pos;

  // Decode the current position and compute the next one (wrap at TOTAL-1).
  always_comb begin
    pos     = int'(count_q);
    term    = (pos == TOTAL - 1);
    active  = (pos < ACTIVE_LEN);
    sync    = (pos >= SYNC_START) && (pos < SYNC_START + SYNC_LEN);
    count_d = count_q;
    if (step) begin
      count_d = term ? '0 : count_q + W'(1);
    end
  end

  // Position register, cleared asynchronously.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: drives position, sync, active flag and line/frame pulses onto the pixel bus.
// Latency: a pixel is presented one clk after the en edge that sampled its position.
// No backpressure: outputs hold while en=0, pulses drop to 0. Optional frame_cnt port: VGA_TIMING_FRAME_CNT_EN.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        en,
  vga.out             o,
  output logic        line_start,
  output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] frame_cnt
`endif
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int X_W     = $clog2(H_TOTAL);
  localparam int Y_W     = $clog2(V_TOTAL);

  // Reject modes whose sync or active regions are empty, or that overflow the bus fields.
  if (H_SYNC < 1 || V_SYNC < 1 || H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_illegal_mode
    $error("vga_timing_gen: H_SYNC, V_SYNC, H_ACTIVE and V_ACTIVE must all be at least 1");
  end
  if (X_W > PXL_W || Y_W > PXL_W) begin : g_pxl_too_narrow
    $error("vga_timing_gen: raster totals exceed the pixel bus position width");
  end

  logic [X_W-1:0] hcnt;
  logic [Y_W-1:0] vcnt;
  logic           h_term, h_act, h_sync;
  logic           v_term, v_act, v_sync;
  logic           v_step;

  assign v_step = en & h_term;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_LEN   (H_SYNC),
    .ACTIVE_LEN (H_ACTIVE)
  ) u_hcnt (
    .clk    (clk),
    .resetN (resetN),
    .step   (en),
    .count  (hcnt),
    .term   (h_term),
    .active (h_act),
    .sync   (h_sync)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_LEN   (V_SYNC),
    .ACTIVE_LEN (V_ACTIVE)
  ) u_vcnt (
    .clk    (clk),
    .resetN (resetN),
    .step   (v_step),
    .count  (vcnt),
    .term   (v_term),
    .active (v_act),
    .sync   (v_sync)
  );

  logic [X_W-1:0] pxl_x_q, pxl_x_d;
  logic [Y_W-1:0] pxl_y_q, pxl_y_d;
  logic           hsync_q, hsync_d;
  logic           vsync_q, vsync_d;
  logic           active_q, active_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;
  // Set while the next pixel to present is (0,0); it is set again by presenting the last pixel.
  logic           frame_pend_q, frame_pend_d;

  // Present the decoded position on en; otherwise hold everything except the pulses.
  always_comb begin
    pxl_x_d       = pxl_x_q;
    pxl_y_d       = pxl_y_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    active_d      = active_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_pend_d  = frame_pend_q;
    if (en) begin
      pxl_x_d       = hcnt;
      pxl_y_d       = vcnt;
      hsync_d       = h_sync ? SYNC_POL : ~SYNC_POL;
      vsync_d       = v_sync ? SYNC_POL : ~SYNC_POL;
      active_d      = h_act & v_act;
      line_start_d  = (hcnt == '0);
      frame_start_d = frame_pend_q;
      frame_pend_d  = h_term & v_term;
    end
  end

  // Output registers; reset parks syncs at their inactive level.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      pxl_x_q       <= '0;
      pxl_y_q       <= '0;
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      active_q      <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_pend_q  <= 1'b1;
    end else begin
      pxl_x_q       <= pxl_x_d;
      pxl_y_q       <= pxl_y_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      active_q      <= active_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      frame_pend_q  <= frame_pend_d;
    end
  end

  assign o.t = '{
    pxl_x:  PXL_W'(pxl_x_q),
    pxl_y:  PXL_W'(pxl_y_q),
    hsync:  hsync_q,
    vsync:  vsync_q,
    active: active_q,
    red:    4'h0,
    green:  4'h0,
    blue:   4'h0
  };

  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Count frames on the same clk the frame_start pulse is registered, so frame 1 reads 1 at (0,0).
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 16'd1;
    end
  end

  // Frame counter register; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 640x480 instance and a small, active-high-sync instance.
// Expected pixels come from the raster rules applied to the count of en pulses since reset.
// Optional frame counter checks follow VGA_TIMING_FRAME_CNT_EN.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  localparam vga_mode_t DM = VGA_MODE_DEFAULT;
  localparam vga_mode_t SM = '{h_active: 16, h_fp: 2, h_sync: 3, h_bp: 4,
                               v_active: 6, v_fp: 1, v_sync: 2, v_bp: 3};
  localparam int S_FRAME = 300;

  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic        hs;
    logic        vs;
    logic        act;
    logic        ls;
    logic        fs;
    logic [11:0] rgb;
  } obs_t;

  logic clk, resetN, en_d, en_s;
  logic ls_d, fs_d, ls_s, fs_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [15:0] fc_d, fc_s;
`endif
  int passed, total, nd, ns;

  vga vif_d ();
  vga vif_s ();

  vga_timing_gen u_dut_def (
    .clk(clk), .resetN(resetN), .en(en_d), .o(vif_d),
    .line_start(ls_d), .frame_start(fs_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_d)
`endif
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) u_dut_sml (
    .clk(clk), .resetN(resetN), .en(en_s), .o(vif_s),
    .line_start(ls_s), .frame_start(fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
    , .frame_cnt(fc_s)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic obs_t get_def();
    obs_t r;
    r.x = vif_d.t.pxl_x; r.y = vif_d.t.pxl_y; r.hs = vif_d.t.hsync; r.vs = vif_d.t.vsync;
    r.act = vif_d.t.active; r.ls = ls_d; r.fs = fs_d;
    r.rgb = {vif_d.t.red, vif_d.t.green, vif_d.t.blue};
    return r;
  endfunction

  function automatic obs_t get_sml();
    obs_t r;
    r.x = vif_s.t.pxl_x; r.y = vif_s.t.pxl_y; r.hs = vif_s.t.hsync; r.vs = vif_s.t.vsync;
    r.act = vif_s.t.active; r.ls = ls_s; r.fs = fs_s;
    r.rgb = {vif_s.t.red, vif_s.t.green, vif_s.t.blue};
    return r;
  endfunction

  // Reference: after n en pulses, pixel number n-1 of the raster is on display.
  function automatic obs_t model(input vga_mode_t m, input bit pol, input int n, input bit en_now);
    obs_t e;
    int ht, vt, k, x, y, hs0, vs0;
    e = '0;
    e.hs = ~pol;
    e.vs = ~pol;
    if (n == 0) return e;
    ht = m.h_active + m.h_fp + m.h_sync + m.h_bp;
    vt = m.v_active + m.v_fp + m.v_sync + m.v_bp;
    k = n - 1;
    x = k % ht;
    y = (k / ht) % vt;
    hs0 = m.h_active + m.h_fp;
    vs0 = m.v_active + m.v_fp;
    e.x = 12'(x);
    e.y = 12'(y);
    e.act = (x < m.h_active) && (y < m.v_active);
    e.hs = (x >= hs0 && x < hs0 + m.h_sync) ? pol : ~pol;
    e.vs = (y >= vs0 && y < vs0 + m.v_sync) ? pol : ~pol;
    e.ls = en_now && (x == 0);
    e.fs = en_now && (x == 0) && (y == 0);
    return e;
  endfunction

  function automatic string fmt(input obs_t v);
    return $sformatf("(%0d,%0d) hs=%0b vs=%0b act=%0b ls=%0b fs=%0b rgb=%03h",
                     v.x, v.y, v.hs, v.vs, v.act, v.ls, v.fs, v.rgb);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (en_d) nd++;
    if (en_s) ns++;
  endtask

  task automatic test_reset();
    obs_t o, e;
    #2 resetN = 1'b0;
    #1;
    o = get_def(); e = model(DM, 1'b0, 0, 1'b0);
    total++;
    if (o !== e) $display("FAIL reset_def got %s want %s", fmt(o), fmt(e)); else passed++;
    repeat (2) @(posedge clk);
    #1;
    o = get_sml(); e = model(SM, 1'b1, 0, 1'b0);
    total++;
    if (o !== e) $display("FAIL reset_sml got %s want %s", fmt(o), fmt(e)); else passed++;
`ifdef VGA_TIMING_FRAME_CNT_EN
    total++;
    if (fc_d !== 16'd0 || fc_s !== 16'd0) $display("FAIL reset_frame_cnt got %0d/%0d want 0", fc_d, fc_s);
    else passed++;
`endif
    resetN = 1'b1;
    nd = 0;
    ns = 0;
  endtask

  task automatic test_first_pixel();
    obs_t o, e;
    en_d = 1'b1;
    tick();
    o = get_def();
    total++;
    if (o.x !== 12'd0 || o.y !== 12'd0 || o.act !== 1'b1 || o.ls !== 1'b1 || o.fs !== 1'b1 ||
        o.hs !== 1'b1 || o.vs !== 1'b1 || o.rgb !== 12'h000)
      $display("FAIL first_pixel got %s want (0,0) hs=1 vs=1 act=1 ls=1 fs=1 rgb=000", fmt(o));
    else passed++;
    o = get_sml(); e = model(SM, 1'b1, ns, en_s);
    total++;
    if (o !== e) $display("FAIL idle_sml got %s want %s", fmt(o), fmt(e)); else passed++;
`ifdef VGA_TIMING_FRAME_CNT_EN
    total++;
    if (fc_d !== 16'd1) $display("FAIL first_frame_cnt got %0d want 1", fc_d); else passed++;
`endif
  endtask

  task automatic test_line_sweep();
    obs_t o, e, p;
    int hs_lo, hs_min, hs_max, act_drop;
    bit wrap_seen;
    hs_lo = 0; hs_min = -1; hs_max = -1; act_drop = -1; wrap_seen = 1'b0;
    p = get_def();
    for (int i = 0; i < 1700; i++) begin
      tick();
      o = get_def(); e = model(DM, 1'b0, nd, en_d);
      total++;
      if (o !== e) $display("FAIL line_sweep n=%0d got %s want %s", nd, fmt(o), fmt(e)); else passed++;
      if (o.y == 12'd0 && o.hs == 1'b0) begin
        hs_lo++;
        if (hs_min < 0) hs_min = int'(o.x);
        hs_max = int'(o.x);
      end
      if (o.y == 12'd0 && o.act == 1'b0 && act_drop < 0) act_drop = int'(o.x);
      if (p.x == 12'd799 && p.y == 12'd0) begin
        wrap_seen = 1'b1;
        total++;
        if (o.x !== 12'd0 || o.y !== 12'd1 || o.ls !== 1'b1 || o.fs !== 1'b0)
          $display("FAIL line_wrap got %s want (0,1) ls=1 fs=0", fmt(o));
        else passed++;
      end
      p = o;
    end
    total++;
    if (hs_lo != 96) $display("FAIL hsync_len got %0d want 96", hs_lo); else passed++;
    total++;
    if (hs_min != 656 || hs_max != 751) $display("FAIL hsync_span got %0d..%0d want 656..751", hs_min, hs_max);
    else passed++;
    total++;
    if (act_drop != 640) $display("FAIL active_drop got %0d want 640", act_drop); else passed++;
    total++;
    if (!wrap_seen) $display("FAIL line_wrap_seen got 0 want 1"); else passed++;
  endtask

  task automatic test_frame_wrap();
    obs_t o, e, p;
    int fs_cyc[$];
    int vs_cnt;
    bit fwrap_seen;
    vs_cnt = 0; fwrap_seen = 1'b0;
    en_d = 1'b0;
    en_s = 1'b1;
    p = get_sml();
    for (int i = 0; i < 3 * S_FRAME; i++) begin
      tick();
      o = get_sml(); e = model(SM, 1'b1, ns, en_s);
      total++;
      if (o !== e) $display("FAIL frame_run n=%0d got %s want %s", ns, fmt(o), fmt(e)); else passed++;
      if (o.fs === 1'b1) begin
        fs_cyc.push_back(i);
`ifdef VGA_TIMING_FRAME_CNT_EN
        total++;
        if (fc_s !== 16'(fs_cyc.size())) $display("FAIL frame_cnt got %0d want %0d", fc_s, fs_cyc.size());
        else passed++;
`endif
      end
      if (fs_cyc.size() == 1 && o.vs === 1'b1) vs_cnt++;
      if (p.x == 12'd24 && p.y == 12'd11) begin
        fwrap_seen = 1'b1;
        total++;
        if (o.x !== 12'd0 || o.y !== 12'd0 || o.fs !== 1'b1)
          $display("FAIL frame_wrap got %s want (0,0) fs=1", fmt(o));
        else passed++;
      end
      p = o;
    end
    total++;
    if (fs_cyc.size() != 3) $display("FAIL frame_starts got %0d want 3", fs_cyc.size()); else passed++;
    for (int j = 1; j < fs_cyc.size(); j++) begin
      total++;
      if (fs_cyc[j] - fs_cyc[j-1] != S_FRAME)
        $display("FAIL frame_period got %0d want %0d", fs_cyc[j] - fs_cyc[j-1], S_FRAME);
      else passed++;
    end
    total++;
    if (vs_cnt != 50) $display("FAIL vsync_len got %0d want 50", vs_cnt); else passed++;
    total++;
    if (!fwrap_seen) $display("FAIL frame_wrap_seen got 0 want 1"); else passed++;
  endtask

  task automatic test_en_random();
    obs_t o, e;
    for (int i = 0; i < 800; i++) begin
      en_s = 1'($urandom_range(0, 1));
      tick();
      o = get_sml(); e = model(SM, 1'b1, ns, en_s);
      total++;
      if (o !== e) $display("FAIL en_random n=%0d en=%0b got %s want %s", ns, en_s, fmt(o), fmt(e));
      else passed++;
    end
  endtask

  task automatic test_en_alternate();
    obs_t o, e;
    int fs_cyc[$];
    en_s = 1'b0;
    for (int i = 0; i < 1400; i++) begin
      en_s = ~en_s;
      tick();
      o = get_sml(); e = model(SM, 1'b1, ns, en_s);
      total++;
      if (o !== e) $display("FAIL en_alt n=%0d en=%0b got %s want %s", ns, en_s, fmt(o), fmt(e));
      else passed++;
      if (o.fs === 1'b1) fs_cyc.push_back(i);
    end
    total++;
    if (fs_cyc.size() < 2) $display("FAIL en_alt_starts got %0d want >=2", fs_cyc.size()); else passed++;
    for (int j = 1; j < fs_cyc.size(); j++) begin
      total++;
      if (fs_cyc[j] - fs_cyc[j-1] != 2 * S_FRAME)
        $display("FAIL en_alt_period got %0d want %0d", fs_cyc[j] - fs_cyc[j-1], 2 * S_FRAME);
      else passed++;
    end
  endtask

  task automatic test_async_reset();
    obs_t o, e;
    bit found;
    found = 1'b0;
    en_s = 1'b1;
    for (int i = 0; i < 400 && !found; i++) begin
      tick();
      o = get_sml();
      if (o.x == 12'd10 && o.y == 12'd3) found = 1'b1;
    end
    total++;
    if (!found) $display("FAIL reach_10_3 got %s want (10,3) within 400 clks", fmt(get_sml())); else passed++;
    #2 resetN = 1'b0;
    #1;
    o = get_sml(); e = model(SM, 1'b1, 0, 1'b0);
    total++;
    if (o !== e) $display("FAIL async_reset got %s want %s", fmt(o), fmt(e)); else passed++;
`ifdef VGA_TIMING_FRAME_CNT_EN
    total++;
    if (fc_s !== 16'd0) $display("FAIL async_frame_cnt got %0d want 0", fc_s); else passed++;
`endif
    @(posedge clk);
    #1;
    o = get_sml();
    total++;
    if (o !== e) $display("FAIL reset_hold got %s want %s", fmt(o), fmt(e)); else passed++;
    resetN = 1'b1;
    nd = 0;
    ns = 0;
    tick();
    o = get_sml();
    total++;
    if (o.x !== 12'd0 || o.y !== 12'd0 || o.act !== 1'b1 || o.ls !== 1'b1 || o.fs !== 1'b1)
      $display("FAIL post_reset_pixel got %s want (0,0) act=1 ls=1 fs=1", fmt(o));
    else passed++;
    for (int i = 0; i < 30; i++) begin
      tick();
      o = get_sml(); e = model(SM, 1'b1, ns, en_s);
      total++;
      if (o !== e) $display("FAIL post_reset_run n=%0d got %s want %s", ns, fmt(o), fmt(e)); else passed++;
    end
  endtask

  initial begin
    passed = 0; total = 0; nd = 0; ns = 0;
    en_d = 1'b0; en_s = 1'b0; resetN = 1'b1;
    test_reset();
    test_first_pixel();
    test_line_sweep();
    test_frame_wrap();
    test_en_random();
    test_en_alternate();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
